pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Central hazard/flush controller for the six-stage in-order pipeline (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into the stall_out[5:0] vector consumed by every inter-stage register (pc_reg, if_id, id_ex, exe_mem, mem_wb).
- Sequences one-cycle pipeline flushes for exceptions.
- Guards against a hung memory bus with a timeout that forces an exception flush.

Parameters:
- TIMEOUT_CYCLES, 64: consecutive MEM-stall cycles before a bus timeout fires. Legal range 2..65535.
- EXC_VECTOR, 32'h0000_0100: PC driven on new_pc_out for a bus-timeout flush.
- CNT_W, 16: width of the internal timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk_in, input, 1: clock. All state updates on the rising edge.
- reset_in, input, 1: synchronous, active-low reset.
- stallreq_if_in, input, 1: IF stage requests stall (instruction bus wait).
- stallreq_id_in, input, 1: ID stage requests stall (load-use hazard).
- stallreq_ex_in, input, 1: EX stage requests stall (multi-cycle mul/div).
- stallreq_mem_in, input, 1: MEM stage requests stall (data bus wait).
- flush_req_in, input, 1: exception/eret detected in MEM; sampled every cycle.
- flush_pc_in, input, 32: target PC accompanying flush_req_in.
- stall_out, output, 6: per-stage hold. Bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB. 1 = STOP.
- flush_out, output, 1: all pipeline registers load bubbles this cycle.
- new_pc_out, output, 32: PC to load while flush_out is 1.
- timeout_out, output, 1: one-cycle pulse, coincident with a timeout-caused flush_out.

Behaviour:
- Reset (reset_in == 0 at a clock edge):
  - state = RUN, timeout counter = 0.
  - flush_out = 0, new_pc_out = 0, timeout_out = 0.
  - stall_out reads 6'b000000 while in reset.
- States: RUN, MEMWAIT, FLUSH.
- stall_out is combinational from the current state and the request inputs. The highest stage wins:
  - mem → 6'b011111
  - else ex → 6'b001111
  - else id → 6'b000111
  - else if → 6'b000011
  - else 6'b000000
  - In FLUSH, stall_out is forced to 6'b000000.
- flush_out, new_pc_out and timeout_out are registered. They assert the cycle after the triggering condition is sampled.
- RUN:
  - flush_req_in = 1 → FLUSH, new_pc_out <= flush_pc_in.
  - Else stallreq_mem_in = 1 → MEMWAIT, counter <= 1.
  - Else stay in RUN.
- MEMWAIT:
  - flush_req_in = 1 → FLUSH with flush_pc_in; this has priority over timeout.
  - Else stallreq_mem_in = 0 → RUN, counter <= 0.
  - Else counter == TIMEOUT_CYCLES-1 → FLUSH, new_pc_out <= EXC_VECTOR, timeout_out <= 1.
  - Else counter increments. The counter saturates; it never wraps.
- FLUSH:
  - flush_out = 1 for exactly one cycle, then → RUN. Counter cleared; timeout_out cleared.
  - Requests arriving during FLUSH are ignored; a flush_req_in held across FLUSH re-triggers from RUN one cycle later.
- new_pc_out holds its last value outside FLUSH.
- Simultaneous flush_req_in and stall requests: the flush wins for state. stall_out still reflects the stall requests in that same (pre-flush) cycle.
- Reset asserted mid-MEMWAIT or mid-FLUSH aborts to RUN at that edge; no flush or timeout pulse is emitted.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- Defined:
  - Adds outputs stall_cycles_out [31:0] and flush_count_out [15:0].
  - stall_cycles_out increments on every non-reset cycle with stall_out != 0.
  - flush_count_out increments on every cycle with flush_out == 1.
  - Both counters wrap modulo 2^N and clear on reset.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset low 2 cycles, then high, no requests → stall_out = 6'b000000, flush_out = 0, new_pc_out = 0.
- stallreq_id_in and stallreq_ex_in both 1 for 3 cycles → stall_out = 6'b001111 in all 3 cycles; no flush.
- flush_req_in = 1 for one cycle with flush_pc_in = 32'h0000_2000 → next cycle flush_out = 1, new_pc_out = 32'h0000_2000, stall_out = 0; the following cycle flush_out = 0, state RUN.
- TIMEOUT_CYCLES = 4, stallreq_mem_in held high → stall_out = 6'b011111 for 4 cycles. On the 5th cycle flush_out = 1, timeout_out = 1, new_pc_out = 32'h0000_0100.
- stallreq_mem_in high 3 cycles, then flush_req_in = 1 with 32'h0000_3000 on cycle 3 (TIMEOUT_CYCLES = 4) → flush to 32'h0000_3000; timeout_out stays 0.
- Reset pulled low while in MEMWAIT at count 2 → next cycle all registered outputs 0; flush_out never pulses. With PIPELINE_CTRL_PERF_EN, stall_cycles_out = 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: merges stage stall requests and sequences exception/bus-timeout flushes
// Optional PIPELINE_CTRL_PERF_EN adds stall-cycle and flush-count performance counters.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0100,
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        stallreq_if_in,
  input  logic        stallreq_id_in,
  input  logic        stallreq_ex_in,
  input  logic        stallreq_mem_in,
  input  logic        flush_req_in,
  input  logic [31:0] flush_pc_in,
  output logic [5:0]  stall_out,
  output logic        flush_out,
  output logic [31:0] new_pc_out,
  output logic        timeout_out
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles_out,
  output logic [15:0] flush_count_out
`endif
);
  typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [31:0] r_pc, w_pc;
  logic r_flush, r_to, w_to;
  logic [5:0] w_stall;
  always_comb begin
    w_stall = (!reset_in || r_state == FLUSH) ? 6'b000000 :
              stallreq_mem_in ? 6'b011111 :
              stallreq_ex_in  ? 6'b001111 :
              stallreq_id_in  ? 6'b000111 :
              stallreq_if_in  ? 6'b000011 : 6'b000000;
    w_next = r_state;
    w_cnt = r_cnt;
    w_pc = flush_pc_in;
    w_to = 1'b0;
    case (r_state)
      RUN: begin
        if (flush_req_in) begin
          w_next = FLUSH;
        end else if (stallreq_mem_in) begin
          w_next = MEMWAIT;
          w_cnt = CNT_W'(1);
        end
      end
      MEMWAIT: begin
        if (flush_req_in) begin
          w_next = FLUSH;
          w_cnt = '0;
        end else if (!stallreq_mem_in) begin
          w_next = RUN;
          w_cnt = '0;
        end else if (r_cnt == LAST) begin
          w_next = FLUSH;
          w_cnt = '0;
          w_pc = EXC_VECTOR;
          w_to = 1'b1;
        end else begin
          w_cnt = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next = RUN;
        w_cnt = '0;
      end
    endcase
  end
  // FLUSH always returns to RUN, so entering FLUSH marks exactly one flush cycle
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      r_state <= RUN;
      r_cnt <= '0;
      r_pc <= '0;
      r_flush <= 1'b0;
      r_to <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_flush <= (w_next == FLUSH);
      r_to <= w_to;
      if (w_next == FLUSH) r_pc <= w_pc;
    end
  end
  assign stall_out = w_stall;
  assign flush_out = r_flush;
  assign new_pc_out = r_pc;
  assign timeout_out = r_to;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      r_stall_cycles <= '0;
      r_flush_count <= '0;
    end else begin
      if (|w_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (r_flush) r_flush_count <= r_flush_count + 16'd1;
    end
  end
  assign stall_cycles_out = r_stall_cycles;
  assign flush_count_out = r_flush_count;
`endif
endmodule
